gshare_predictor: RTL and testbench

- Parametrised successor to the 2-bit pattern history table.
- Global-history (gshare) branch direction predictor:
  - Saturating counters of configurable width.
  - Table index = PC index XOR global history register (GHR).
  - GHR updated speculatively, with mispredict recovery.
  - Table cleared by a post-reset init walk.
- Sits in the fetch stage. Resolved-branch feedback arrives from execute/ROB commit.

---
 rtl/gshare_predictor.sv | 112 +++++++++++
 tb/tb_gshare_predictor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: PC index XOR global history selects a
// saturating counter; history is shifted speculatively and repaired on mispredict.
module gshare_predictor #(
    parameter int unsigned CTR_WIDTH  = 2,
    parameter int unsigned INDEX_BITS = 7,
    parameter int unsigned HIST_BITS  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_valid,
    input  logic [INDEX_BITS-1:0] pred_pc_idx,
    output logic                  pred_ready,
    output logic                  pred_taken,
    output logic [HIST_BITS-1:0]  pred_hist,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_pc_idx,
    input  logic [HIST_BITS-1:0]  upd_hist,
    input  logic                  upd_taken,
    input  logic                  upd_mispredict
);

    localparam int unsigned DEPTH = 2 ** INDEX_BITS;
    localparam logic [CTR_WIDTH-1:0] CTR_WNT = {1'b0, {(CTR_WIDTH-1){1'b1}}};
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_MIN = '0;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state;
    logic [INDEX_BITS-1:0]   init_ptr;
    logic [HIST_BITS-1:0]    ghr;
    logic [CTR_WIDTH-1:0]    ctr_tab [DEPTH];

    logic [INDEX_BITS-1:0]   pidx;
    logic [INDEX_BITS-1:0]   uidx;
    logic                    pred_dir;
    logic [CTR_WIDTH-1:0]    upd_cur;
    logic [CTR_WIDTH-1:0]    upd_next;
    logic [HIST_BITS:0]      spec_ext;
    logic [HIST_BITS:0]      rec_ext;
    logic                    running;

    assign running  = (state == ST_RUN);
    assign pidx     = pred_pc_idx ^ INDEX_BITS'(ghr);
    assign uidx     = upd_pc_idx ^ INDEX_BITS'(upd_hist);
    assign pred_dir = ctr_tab[pidx][CTR_WIDTH-1];
    assign upd_cur  = ctr_tab[uidx];

    // Shift-in is formed on a one-bit-wider vector so HIST_BITS=1 needs no special case.
    assign spec_ext = {ghr, pred_dir};
    assign rec_ext  = {upd_hist, upd_taken};

    assign pred_taken = running & pred_dir;
    assign pred_hist  = running ? ghr : '0;

    always_comb begin
        upd_next = upd_cur;
        if (upd_taken) begin
            if (upd_cur != CTR_MAX) begin
                upd_next = upd_cur + CTR_WIDTH'(1);
            end
        end else begin
            if (upd_cur != CTR_MIN) begin
                upd_next = upd_cur - CTR_WIDTH'(1);
            end
        end
    end

    // Table storage is left unreset; the init walk clears it after every reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                ctr_tab[init_ptr] <= CTR_WNT;
            end else if (upd_valid) begin
                ctr_tab[uidx] <= upd_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            init_ptr   <= '0;
            ghr        <= '0;
            pred_ready <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_ptr <= init_ptr + INDEX_BITS'(1);
                    if (init_ptr == '1) begin
                        state      <= ST_RUN;
                        pred_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (upd_valid && upd_mispredict) begin
                        ghr <= rec_ext[HIST_BITS-1:0];
                    end else if (pred_valid) begin
                        ghr <= spec_ext[HIST_BITS-1:0];
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Checks gshare_predictor (default and a 3/4/2 configuration) against a
// behavioural table/history model plus hand-computed directed expectations.
module tb_gshare_predictor;

    logic clk;
    logic rst;

    logic       a_pv, a_uv, a_ut, a_um, a_ready, a_taken;
    logic [6:0] a_ppc, a_upc, a_uh, a_hist;
    logic       b_pv, b_uv, b_ut, b_um, b_ready, b_taken;
    logic [3:0] b_ppc, b_upc;
    logic [1:0] b_uh, b_hist;

    int pv [2];
    int ppc[2];
    int uv [2];
    int upc[2];
    int uh [2];
    int ut [2];
    int um [2];

    int n_vec;
    int n_bad;

    assign a_pv  = (pv[0] != 0);
    assign a_ppc = 7'(ppc[0]);
    assign a_uv  = (uv[0] != 0);
    assign a_upc = 7'(upc[0]);
    assign a_uh  = 7'(uh[0]);
    assign a_ut  = (ut[0] != 0);
    assign a_um  = (um[0] != 0);
    assign b_pv  = (pv[1] != 0);
    assign b_ppc = 4'(ppc[1]);
    assign b_uv  = (uv[1] != 0);
    assign b_upc = 4'(upc[1]);
    assign b_uh  = 2'(uh[1]);
    assign b_ut  = (ut[1] != 0);
    assign b_um  = (um[1] != 0);

    gshare_predictor dut_a (
        .clk(clk), .rst(rst),
        .pred_valid(a_pv), .pred_pc_idx(a_ppc),
        .pred_ready(a_ready), .pred_taken(a_taken), .pred_hist(a_hist),
        .upd_valid(a_uv), .upd_pc_idx(a_upc), .upd_hist(a_uh),
        .upd_taken(a_ut), .upd_mispredict(a_um)
    );

    gshare_predictor #(.CTR_WIDTH(3), .INDEX_BITS(4), .HIST_BITS(2)) dut_b (
        .clk(clk), .rst(rst),
        .pred_valid(b_pv), .pred_pc_idx(b_ppc),
        .pred_ready(b_ready), .pred_taken(b_taken), .pred_hist(b_hist),
        .upd_valid(b_uv), .upd_pc_idx(b_upc), .upd_hist(b_uh),
        .upd_taken(b_ut), .upd_mispredict(b_um)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int CW[2] = '{2, 3};
    int IB[2] = '{7, 4};
    int HB[2] = '{7, 2};
    int m_run[2];
    int m_ptr[2];
    int m_ghr[2];
    int m_tab[2][128];
    bit known;
    int act_r[2], act_t[2], act_h[2];
    int dep, mx, hm, pidx, uidx, e_r, e_t, e_h;

    initial begin
        known = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_ptr[k] = 0; m_ghr[k] = 0;
        end
        forever begin
            @(negedge clk);
            act_r[0] = int'(a_ready); act_t[0] = int'(a_taken); act_h[0] = int'(a_hist);
            act_r[1] = int'(b_ready); act_t[1] = int'(b_taken); act_h[1] = int'(b_hist);
            for (int k = 0; k < 2; k++) begin
                dep  = 1 << IB[k];
                mx   = (1 << CW[k]) - 1;
                hm   = (1 << HB[k]) - 1;
                pidx = (ppc[k] ^ m_ghr[k]) & (dep - 1);
                if (m_run[k] != 0) begin
                    e_r = 1;
                    e_t = (m_tab[k][pidx] >= (1 << (CW[k] - 1))) ? 1 : 0;
                    e_h = m_ghr[k];
                end else begin
                    e_r = 0; e_t = 0; e_h = 0;
                end
                if (known) begin
                    chk(k == 0 ? "a_ready" : "b_ready", act_r[k], e_r);
                    chk(k == 0 ? "a_taken" : "b_taken", act_t[k], e_t);
                    chk(k == 0 ? "a_hist"  : "b_hist",  act_h[k], e_h);
                end
                if (rst) begin
                    m_run[k] = 0; m_ptr[k] = 0; m_ghr[k] = 0;
                end else if (m_run[k] == 0) begin
                    m_tab[k][m_ptr[k]] = (1 << (CW[k] - 1)) - 1;
                    m_ptr[k]++;
                    if (m_ptr[k] == dep) m_run[k] = 1;
                end else begin
                    if (uv[k] != 0) begin
                        uidx = (upc[k] ^ (uh[k] & hm)) & (dep - 1);
                        if (ut[k] != 0) begin
                            if (m_tab[k][uidx] < mx) m_tab[k][uidx]++;
                        end else begin
                            if (m_tab[k][uidx] > 0) m_tab[k][uidx]--;
                        end
                    end
                    if (uv[k] != 0 && um[k] != 0)
                        m_ghr[k] = (((uh[k] & hm) << 1) | (ut[k] != 0 ? 1 : 0)) & hm;
                    else if (pv[k] != 0)
                        m_ghr[k] = ((m_ghr[k] << 1) | e_t) & hm;
                end
            end
            if (rst) known = 1'b1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle(input int k);
        pv[k] = 0; ppc[k] = 0; uv[k] = 0; upc[k] = 0; uh[k] = 0; ut[k] = 0; um[k] = 0;
    endtask

    task automatic scan_all(input string nm);
        for (int p = 0; p < 128; p++) begin
            ppc[0] = p;
            ppc[1] = p % 16;
            settle();
            chk(nm, a_taken, 0);
            chk(nm, b_taken, 0);
            next();
        end
        ppc[0] = 0;
        ppc[1] = 0;
    endtask

    int na, nb;
    int sat_exp[6]  = '{1, 1, 1, 1, 0, 0};
    int bsat_exp[17] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int g_exp[4]    = '{0, 1, 3, 3};

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle(0);
        idle(1);
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;
        chk("init_ready_low", a_ready, 0);

        // Init walk, with updates/predictions issued that must be ignored.
        na = 0; nb = 0;
        for (int i = 1; i <= 300 && na == 0; i++) begin
            if (i >= 20 && i <= 30) begin
                pv[0] = 1; ppc[0] = 7; uv[0] = 1; upc[0] = 5; uh[0] = 0; ut[0] = 1; um[0] = 1;
            end else idle(0);
            if (i >= 8 && i <= 12) begin
                pv[1] = 1; uv[1] = 1; upc[1] = 5; uh[1] = 0; ut[1] = 1; um[1] = 1;
            end else idle(1);
            next();
            if (nb == 0 && b_ready) nb = i;
            if (a_ready) na = i;
        end
        idle(0);
        idle(1);
        chk("init_len_a", na, 128);
        chk("init_len_b", nb, 16);
        chk("init_hist", a_hist, 0);
        scan_all("init_nt");

        // Saturation on entry 3.
        ppc[0] = 3; uv[0] = 1; upc[0] = 3; uh[0] = 0; ut[0] = 1;
        settle();
        chk("sat_before", a_taken, 0);
        for (int i = 0; i < 6; i++) begin
            uv[0] = 1; upc[0] = 3; uh[0] = 0; ut[0] = (i < 3) ? 1 : 0; ppc[0] = 3;
            next();
            settle();
            chk("sat_a", a_taken, sat_exp[i]);
        end
        idle(0);
        next();

        // History shift: train entry 0 to strongly taken.
        uv[0] = 1; upc[0] = 0; uh[0] = 0; ut[0] = 1;
        next();
        next();
        idle(0);
        pv[0] = 1; ppc[0] = 0;
        settle();
        chk("hist_taken0", a_taken, 1);
        chk("hist_snap0", a_hist, 0);
        next();
        pv[0] = 0; ppc[0] = 1;
        settle();
        chk("hist_ghr1", a_hist, 1);
        chk("hist_taken1", a_taken, 1);
        next();

        // Mispredict recovery and its priority over the speculative shift.
        uv[0] = 1; um[0] = 1; uh[0] = 'h15; ut[0] = 0; upc[0] = 0;
        next();
        idle(0);
        settle();
        chk("rec_setup", a_hist, 'h2A);
        uv[0] = 1; um[0] = 1; uh[0] = 'h15; ut[0] = 1; upc[0] = 0; pv[0] = 1; ppc[0] = 0;
        next();
        idle(0);
        settle();
        chk("rec_prio", a_hist, 'h2B);
        um[0] = 1; uh[0] = 'h40;
        next();
        idle(0);
        settle();
        chk("mis_novalid", a_hist, 'h2B);
        next();

        // Collision on index 9: old value this cycle, new value next cycle.
        ppc[0] = 9 ^ 'h2B; uv[0] = 1; upc[0] = 9; uh[0] = 0; ut[0] = 1;
        settle();
        chk("coll_same", a_taken, 0);
        next();
        idle(0);
        ppc[0] = 9 ^ 'h2B;
        settle();
        chk("coll_next", a_taken, 1);
        next();

        // Mixed traffic, checked by the model only.
        for (int i = 0; i < 200; i++) begin
            pv[0]  = (i % 3 != 0) ? 1 : 0;
            ppc[0] = (i * 37 + 11) & 127;
            uv[0]  = i % 2;
            upc[0] = (i * 53 + 5) & 127;
            uh[0]  = (i * 29) & 127;
            ut[0]  = (((i * 7) % 5) < 3) ? 1 : 0;
            um[0]  = (i % 11 == 0) ? 1 : 0;
            next();
        end
        idle(0);

        // Reset in the middle of operation.
        rst = 1'b1;
        next();
        rst = 1'b0;
        chk("rst_ready_a", a_ready, 0);
        chk("rst_hist_a", a_hist, 0);
        chk("rst_ready_b", b_ready, 0);
        na = 0;
        for (int i = 1; i <= 300 && na == 0; i++) begin
            next();
            if (a_ready) na = i;
        end
        chk("reinit_len_a", na, 128);
        scan_all("reinit_nt");

        // Narrow configuration: 3-bit counters saturate at 7 and 0.
        for (int i = 0; i < 17; i++) begin
            uv[1] = 1; upc[1] = 5; uh[1] = 0; ppc[1] = 5;
            ut[1] = (i < 5 || i >= 13) ? 1 : 0;
            next();
            settle();
            chk("sat_b", b_taken, bsat_exp[i]);
        end
        idle(1);
        next();

        // Narrow configuration: 2-bit history wraps.
        for (int i = 0; i < 4; i++) begin
            pv[1] = 1; ppc[1] = 5 ^ g_exp[i];
            settle();
            chk("ghr_b", b_hist, g_exp[i]);
            chk("ghr_b_taken", b_taken, 1);
            next();
        end
        idle(1);
        next();
        next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
